// File: rtl/circuit1_pkg.sv
// Shared constants, record type and saturating-add helper for the circuit1 frame collector.
package circuit1_pkg;

    localparam int unsigned Z_W       = 8;
    localparam int unsigned X_W       = 16;
    localparam int unsigned ACC_W_DEF = 24;

    // Default record layout; the collector re-declares it with its own ACC_W.
    typedef struct packed {
        logic signed [ACC_W_DEF-1:0] sum;
        logic signed [Z_W-1:0]       min;
        logic signed [Z_W-1:0]       max;
        logic                        sat;
    } frame_rec_t;

    typedef struct packed {
        logic signed [63:0] sum;
        logic               sat;
    } sat_res_t;

    // Operands arrive sign-extended to 64 bits; the result is clamped to a w-bit signed range.
    function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                         input logic signed [63:0] b,
                                         input int unsigned        w);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_res_t           r;
        s     = a + b;
        hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo    = -(64'sd1 <<< (w - 1));
        r.sum = s;
        r.sat = 1'b0;
        if (s > hi) begin
            r.sum = hi;
            r.sat = 1'b1;
        end else if (s < lo) begin
            r.sum = lo;
            r.sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/circuit1_frame_collector_if.sv
// Sample input and frame record output bundle of the circuit1 frame collector.
interface circuit1_frame_collector_if #(
    parameter int unsigned ACC_W = 24
);
    import circuit1_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic signed [Z_W-1:0]   z;
    logic signed [X_W-1:0]   x;
    logic                    frame_valid;
    logic                    frame_ready;
    logic signed [ACC_W-1:0] frame_sum;
    logic signed [Z_W-1:0]   frame_min;
    logic signed [Z_W-1:0]   frame_max;
    logic                    frame_sat;

    modport master (
        output in_valid, z, x, frame_ready,
        input  in_ready, frame_valid, frame_sum, frame_min, frame_max, frame_sat
    );

    modport slave (
        input  in_valid, z, x, frame_ready,
        output in_ready, frame_valid, frame_sum, frame_min, frame_max, frame_sat
    );

endinterface

// File: rtl/frame_fifo2.sv
// Two-entry first-in first-out queue of frame records with a valid/ready read side.
module frame_fifo2
    import circuit1_pkg::*;
#(
    parameter type rec_t = frame_rec_t
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  rec_t       push_rec,
    input  logic       pop_ready,
    output rec_t       head,
    output logic       head_valid,
    output logic [1:0] count
);

    rec_t       mem_q [2];
    logic       wr_q;
    logic       rd_q;
    logic [1:0] count_q;
    logic       pop;
    logic       do_push;

    assign head_valid = (count_q != 2'd0);
    assign head       = mem_q[rd_q];
    assign count      = count_q;
    assign pop        = head_valid & pop_ready;
    // A push into a full queue only lands when the head leaves on the same edge.
    assign do_push    = push & ((count_q != 2'd2) | pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_rec;
                wr_q        <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/circuit1_frame_collector.sv
// Aligns circuit1 z with its delayed x and reduces FRAME_LEN samples into one queued
// record holding the saturated x sum, z min/max and a sticky saturation flag.
module circuit1_frame_collector
    import circuit1_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 4,
    parameter int unsigned ACC_W     = 24
) (
    input logic                       clk,
    input logic                       rst,
    circuit1_frame_collector_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    typedef struct packed {
        logic signed [ACC_W-1:0] sum;
        logic signed [Z_W-1:0]   min;
        logic signed [Z_W-1:0]   max;
        logic                    sat;
    } rec_t;

    logic [CNT_W-1:0]        cnt_q;
    logic                    s1_valid_q;
    logic                    s1_first_q;
    logic                    s1_last_q;
    logic signed [Z_W-1:0]   s1_z_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [Z_W-1:0]   min_q;
    logic signed [Z_W-1:0]   min_d;
    logic signed [Z_W-1:0]   max_q;
    logic signed [Z_W-1:0]   max_d;
    logic                    sat_q;
    logic                    sat_d;
    sat_res_t                add_r;
    logic                    unused_add_hi;
    logic                    accept;
    logic                    pend;
    logic [1:0]              fifo_count;
    rec_t                    push_rec;
    rec_t                    head;
    logic                    head_valid;

    // The last sample sitting in stage 1 reserves a queue slot before it is pushed.
    assign pend         = s1_valid_q & s1_last_q;
    assign bus.in_ready = (fifo_count + {1'b0, pend}) < 2'd2;
    assign accept       = bus.in_valid & bus.in_ready;

    always_comb begin
        add_r = sat_add({{(64 - ACC_W){acc_q[ACC_W-1]}}, acc_q},
                        {{(64 - X_W){bus.x[X_W-1]}}, bus.x}, ACC_W);
        if (s1_first_q) begin
            acc_d = {{(ACC_W - X_W){bus.x[X_W-1]}}, bus.x};
            min_d = s1_z_q;
            max_d = s1_z_q;
            sat_d = 1'b0;
        end else begin
            acc_d = add_r.sum[ACC_W-1:0];
            min_d = (s1_z_q < min_q) ? s1_z_q : min_q;
            max_d = (s1_z_q > max_q) ? s1_z_q : max_q;
            sat_d = sat_q | add_r.sat;
        end
    end

    // Clamped sums always fit in ACC_W bits, so the upper half carries only sign copies.
    assign unused_add_hi = ^add_r.sum[63:ACC_W];

    assign push_rec = {acc_d, min_d, max_d, sat_d};

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_z_q     <= '0;
            acc_q      <= '0;
            min_q      <= '0;
            max_q      <= '0;
            sat_q      <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_z_q     <= bus.z;
                s1_first_q <= (cnt_q == '0);
                s1_last_q  <= (cnt_q == LAST_IDX);
                cnt_q      <= (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
            end
            if (s1_valid_q) begin
                acc_q <= pend ? '0 : acc_d;
                min_q <= pend ? '0 : min_d;
                max_q <= pend ? '0 : max_d;
                sat_q <= pend ? 1'b0 : sat_d;
            end
        end
    end

    frame_fifo2 #(
        .rec_t (rec_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (pend),
        .push_rec   (push_rec),
        .pop_ready  (bus.frame_ready),
        .head       (head),
        .head_valid (head_valid),
        .count      (fifo_count)
    );

    assign bus.frame_valid = head_valid;
    assign bus.frame_sum   = head.sum;
    assign bus.frame_min   = head.min;
    assign bus.frame_max   = head.max;
    assign bus.frame_sat   = head.sat;

endmodule
